// File: rtl/mul_arb_pkg.sv
// Shared types and opcode constants for the multiplier arbiter.
package mul_arb_pkg;

  localparam int unsigned SLOT_ID_W  = 2;
  localparam int unsigned SLOT_TAG_W = 16;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;

  // One shadow-pipeline entry tracking an op inside the multiplier.
  typedef struct packed {
    logic                  valid;
    logic [SLOT_ID_W-1:0]  id;
    logic [SLOT_TAG_W-1:0] tag;
    logic [2:0]            funct3;
  } slot_t;

endpackage

// File: rtl/mul_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins.
module rr_arbiter #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NREQ-1:0]  grant_o
);

  logic found_c;

  always_comb begin
    grant_o = '0;
    found_c = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!found_c && req_i[i] && (((32'(ptr_i) + k) % NREQ) == i)) begin
          grant_o[i] = 1'b1;
          found_c    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one fixed-latency CE-stalled multiplier among NREQ requesters.
// Optional perf counters enabled by defining MUL_ARBITER_PERF_EN.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned LATENCY = 4,
  parameter int unsigned TAG_W   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*32-1:0]    req_a,
  input  logic [NREQ*32-1:0]    req_b,
  input  logic [NREQ*3-1:0]     req_funct3,
  input  logic [NREQ*TAG_W-1:0] req_tag,
  input  logic [NREQ-1:0]       flush,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [31:0]           rsp_result,
  output logic [TAG_W-1:0]      rsp_tag,
  output logic                  mul_ce,
  output logic [31:0]           mul_a,
  output logic [31:0]           mul_b,
  output logic [2:0]            mul_funct3,
  input  logic [31:0]           mul_result,
  output logic [31:0]           perf_issue,
  output logic [31:0]           perf_bp,
  output logic [31:0]           perf_busy
);

  localparam int unsigned PTR_W = (NREQ > 2) ? 2 : 1;

  slot_t                  slot_q [LATENCY];
  slot_t                  slot_d [LATENCY];
  slot_t                  out_s;
  logic [PTR_W-1:0]       ptr_q, ptr_d, ptr_nxt;
  logic [NREQ-1:0]        elig, grant, hs;
  logic                   hs_any, any_valid, out_rdy, out_fl, out_blk;
  logic [SLOT_ID_W-1:0]   sel_id;
  logic [SLOT_TAG_W-1:0]  sel_tag;
  logic [2:0]             sel_funct3;

  assign out_s = slot_q[LATENCY-1];
  assign elig  = req_valid & ~flush;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req_i   (elig),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  // Output-slot owner's ready/flush decide whether the datapath must freeze.
  always_comb begin
    out_rdy   = 1'b0;
    out_fl    = 1'b0;
    rsp_valid = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (out_s.id == SLOT_ID_W'(i)) begin
        out_rdy = rsp_ready[i];
        out_fl  = flush[i];
      end
      rsp_valid[i] = out_s.valid && (out_s.id == SLOT_ID_W'(i)) && !flush[i];
    end
  end

  assign out_blk = out_s.valid && !out_rdy && !out_fl;

  always_comb begin
    any_valid = 1'b0;
    for (int unsigned k = 0; k < LATENCY; k++) begin
      any_valid = any_valid | slot_q[k].valid;
    end
  end

  assign req_ready  = out_blk ? '0 : grant;
  assign hs         = req_valid & req_ready;
  assign hs_any     = |hs;
  assign mul_ce     = !out_blk && (any_valid || (|grant));
  assign rsp_result = mul_result;
  assign rsp_tag    = TAG_W'(out_s.tag);
  assign mul_funct3 = out_s.valid ? out_s.funct3 : 3'b000;

  // Operand/tag steering from the requester completing a handshake; zero when idle.
  always_comb begin
    mul_a      = '0;
    mul_b      = '0;
    sel_funct3 = '0;
    sel_tag    = '0;
    sel_id     = '0;
    ptr_nxt    = ptr_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (hs[i]) begin
        mul_a      = req_a[32*i +: 32];
        mul_b      = req_b[32*i +: 32];
        sel_funct3 = req_funct3[3*i +: 3];
        sel_tag    = SLOT_TAG_W'(req_tag[TAG_W*i +: TAG_W]);
        sel_id     = SLOT_ID_W'(i);
        ptr_nxt    = PTR_W'((i + 1) % NREQ);
      end
    end
  end

  // Shadow pipeline advances with CE; flush kills matching slots on any edge.
  always_comb begin
    for (int unsigned k = 0; k < LATENCY; k++) begin
      slot_d[k] = slot_q[k];
    end
    ptr_d = ptr_q;
    if (mul_ce) begin
      for (int unsigned k = 1; k < LATENCY; k++) begin
        slot_d[k] = slot_q[k-1];
      end
      slot_d[0] = '0;
      if (hs_any) begin
        slot_d[0].valid  = 1'b1;
        slot_d[0].id     = sel_id;
        slot_d[0].tag    = sel_tag;
        slot_d[0].funct3 = sel_funct3;
        ptr_d            = ptr_nxt;
      end
    end
    for (int unsigned k = 0; k < LATENCY; k++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (flush[i] && (slot_d[k].id == SLOT_ID_W'(i))) begin
          slot_d[k].valid = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < LATENCY; k++) begin
        slot_q[k] <= '0;
      end
      ptr_q <= '0;
    end else begin
      for (int unsigned k = 0; k < LATENCY; k++) begin
        slot_q[k] <= slot_d[k];
      end
      ptr_q <= ptr_d;
    end
  end

`ifdef MUL_ARBITER_PERF_EN
  logic [31:0] perf_issue_q, perf_bp_q, perf_busy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_issue_q <= '0;
      perf_bp_q    <= '0;
      perf_busy_q  <= '0;
    end else begin
      if (hs_any)    perf_issue_q <= perf_issue_q + 32'd1;
      if (out_blk)   perf_bp_q    <= perf_bp_q + 32'd1;
      if (any_valid) perf_busy_q  <= perf_busy_q + 32'd1;
    end
  end

  assign perf_issue = perf_issue_q;
  assign perf_bp    = perf_bp_q;
  assign perf_busy  = perf_busy_q;
`else
  assign perf_issue = '0;
  assign perf_bp    = '0;
  assign perf_busy  = '0;
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: directed table, corner sequences, random traffic vs. a queue model.
module tb_mul_arbiter;
  import mul_arb_pkg::*;

  localparam int NREQ = 2;
  localparam int LAT  = 4;
  localparam int TW   = 5;
`ifdef MUL_ARBITER_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [NREQ-1:0]     req_valid = '0, req_ready, flush = '0, rsp_valid, rsp_ready = '1;
  logic [NREQ*32-1:0]  req_a = '0, req_b = '0;
  logic [NREQ*3-1:0]   req_funct3 = '0;
  logic [NREQ*TW-1:0]  req_tag = '0;
  logic [31:0]         rsp_result, mul_a, mul_b, mul_result;
  logic [TW-1:0]       rsp_tag;
  logic                mul_ce;
  logic [2:0]          mul_funct3;
  logic [31:0]         perf_issue, perf_bp, perf_busy;

  always #5 clk = ~clk;

  mul_arbiter #(.NREQ(NREQ), .LATENCY(LAT), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_funct3(req_funct3), .req_tag(req_tag),
    .flush(flush), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_tag(rsp_tag), .mul_ce(mul_ce),
    .mul_a(mul_a), .mul_b(mul_b), .mul_funct3(mul_funct3), .mul_result(mul_result),
    .perf_issue(perf_issue), .perf_bp(perf_bp), .perf_busy(perf_busy)
  );

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f);
    logic [63:0] xa, xb, p;
    xa = (f == FUNCT3_MULHU) ? {32'b0, a} : {{32{a[31]}}, a};
    xb = (f == FUNCT3_MULH)  ? {{32{b[31]}}, b} : {32'b0, b};
    p  = xa * xb;
    return (f == FUNCT3_MUL) ? p[31:0] : p[63:32];
  endfunction

  // Behavioural multiplier: operands ride a CE-gated LAT-deep pipe, funct3 picks the result half.
  logic [31:0] ma [LAT];
  logic [31:0] mb [LAT];
  always @(posedge clk) begin
    if (mul_ce) begin
      ma[0] <= mul_a;
      mb[0] <= mul_b;
      for (int k = 1; k < LAT; k++) begin
        ma[k] <= ma[k-1];
        mb[k] <= mb[k-1];
      end
    end
  end
  assign mul_result = ref_mul(ma[LAT-1], mb[LAT-1], mul_funct3);

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: in-flight ops in issue order, each aging one step per enabled edge.
  typedef struct {
    int          id;
    logic [4:0]  tag;
    logic [31:0] res;
    logic [2:0]  f3;
    int          age;
  } op_t;
  op_t q[$];
  int  rr_p = 0;
  int  m_issue = 0, m_bp = 0, m_busy = 0;

  logic [NREQ-1:0] obs_ready, obs_rv;
  logic            obs_ce;
  logic [31:0]     obs_res;
  logic [TW-1:0]   obs_tag;

  task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f, input logic [4:0] tag);
    req_a[32*r +: 32]  = a;
    req_b[32*r +: 32]  = b;
    req_funct3[3*r +: 3] = f;
    req_tag[TW*r +: TW]  = tag;
  endtask

  // One clock: check all outputs against the model at negedge, then advance the model.
  task automatic step();
    int g, hid;
    bit present, blk, e_ce;
    logic [NREQ-1:0] e_ready, e_rv;
    logic [31:0] e_a, e_b;
    logic [2:0]  e_f3;
    @(negedge clk);
    present = (q.size() > 0) && (q[0].age == LAT);
    hid     = present ? q[0].id : 0;
    blk     = present && !rsp_ready[hid] && !flush[hid];
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (rr_p + k) % NREQ;
      if (g < 0 && req_valid[idx] && !flush[idx]) g = idx;
    end
    e_ready = '0;
    e_a = '0;
    e_b = '0;
    if (!blk && g >= 0) begin
      e_ready[g] = 1'b1;
      e_a = req_a[32*g +: 32];
      e_b = req_b[32*g +: 32];
    end
    e_ce = !blk && (q.size() > 0 || g >= 0);
    e_rv = '0;
    if (present && !flush[hid]) e_rv[hid] = 1'b1;
    e_f3 = present ? q[0].f3 : 3'b000;

    obs_ready = req_ready;
    obs_rv    = rsp_valid;
    obs_ce    = mul_ce;
    obs_res   = rsp_result;
    obs_tag   = rsp_tag;

    chk("req_ready", req_ready, e_ready);
    chk("rsp_valid", rsp_valid, e_rv);
    chk("mul_ce", mul_ce, e_ce);
    chk("mul_a", mul_a, e_a);
    chk("mul_b", mul_b, e_b);
    chk("mul_funct3", mul_funct3, e_f3);
    if (e_rv != 0) begin
      chk("rsp_result", rsp_result, q[0].res);
      chk("rsp_tag", rsp_tag, q[0].tag);
    end

    m_busy += (q.size() > 0) ? 1 : 0;
    m_bp   += blk ? 1 : 0;
    if (e_ce) begin
      if (present) void'(q.pop_front());
      foreach (q[k]) q[k].age++;
      if (e_ready != 0) begin
        q.push_back('{g, req_tag[TW*g +: TW],
                      ref_mul(req_a[32*g +: 32], req_b[32*g +: 32], req_funct3[3*g +: 3]),
                      req_funct3[3*g +: 3], 1});
        rr_p = (g + 1) % NREQ;
        m_issue++;
      end
    end
    for (int k = q.size() - 1; k >= 0; k--) begin
      if (flush[q[k].id]) q.delete(k);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    flush     = '0;
    rsp_ready = '1;
    #2;
    reset = 1'b1;
    #1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_mul_ce", mul_ce, 0);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_mul_a", mul_a, 0);
    chk("reset_mul_funct3", mul_funct3, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    rr_p = 0;
    m_issue = 0;
    m_bp = 0;
    m_busy = 0;
    chk("reset_perf_issue", perf_issue, 0);
    chk("reset_perf_bp", perf_bp, 0);
    chk("reset_perf_busy", perf_busy, 0);
  endtask

  typedef struct {
    int          r;
    logic [31:0] a, b;
    logic [2:0]  f;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [7];

  // Issue one op on an idle unit and check result, tag and nominal latency.
  task automatic single_op(input vec_t v);
    int lat;
    logic [31:0] res;
    logic [4:0]  tag;
    lat = 99;
    res = '0;
    tag = '0;
    set_req(v.r, v.a, v.b, v.f, v.tag);
    req_valid[v.r] = 1'b1;
    step();
    chk("single_issue_ready", obs_ready[v.r], 1);
    req_valid = '0;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (obs_rv[v.r] && lat == 99) begin
        lat = n;
        res = obs_res;
        tag = obs_tag;
      end
    end
    chk("single_latency", lat, 4);
    chk("single_result", res, v.exp);
    chk("single_tag", tag, v.tag);
  endtask

  initial begin
    logic [NREQ-1:0] exp_g;
    int cnt1, lat0;

    tbl[0] = '{0, 32'd7,        32'hFFFFFFFD, FUNCT3_MUL,    5'd5,  32'hFFFFFFEB};
    tbl[1] = '{1, 32'hFFFFFFFF, 32'hFFFFFFFF, FUNCT3_MULH,   5'd9,  32'h00000000};
    tbl[2] = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF, FUNCT3_MULHU,  5'd31, 32'hFFFFFFFE};
    tbl[3] = '{1, 32'hFFFFFFFF, 32'd2,        FUNCT3_MULHSU, 5'd0,  32'hFFFFFFFF};
    tbl[4] = '{0, 32'h80000000, 32'h80000000, FUNCT3_MULH,   5'd17, 32'h40000000};
    tbl[5] = '{1, 32'h12345678, 32'h00000010, FUNCT3_MUL,    5'd3,  32'h23456780};
    tbl[6] = '{0, 32'h80000000, 32'hFFFFFFFF, FUNCT3_MULHSU, 5'd12, 32'h80000000};

    do_reset();
    for (int i = 0; i < 7; i++) single_op(tbl[i]);

    // Contention from reset: grants alternate starting at requester 0.
    do_reset();
    req_valid = '1;
    for (int k = 0; k < 4; k++) begin
      set_req(0, 32'(k + 1), 32'd3, FUNCT3_MUL, 5'(k));
      set_req(1, 32'(k + 10), 32'd5, FUNCT3_MUL, 5'(k + 16));
      step();
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      chk("contention_grant", obs_ready, exp_g);
    end
    req_valid = '0;
    repeat (8) step();

    // Backpressure: output held while rsp_ready[0] is low.
    set_req(0, 32'd3, 32'd5, FUNCT3_MUL, 5'd1);
    req_valid[0] = 1'b1;
    step();
    set_req(0, 32'd4, 32'd5, FUNCT3_MUL, 5'd2);
    step();
    req_valid = '0;
    step();
    step();
    rsp_ready[0] = 1'b0;
    set_req(1, 32'd9, 32'd9, FUNCT3_MUL, 5'd7);
    req_valid[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_mul_ce", obs_ce, 0);
      chk("bp_req_ready", obs_ready, 0);
      chk("bp_result_held", obs_res, 32'd15);
    end
    req_valid = '0;
    rsp_ready = '1;
    step();
    chk("bp_release_accept", obs_rv, 2'b01);
    step();
    chk("bp_next_valid", obs_rv, 2'b01);
    chk("bp_next_result", obs_res, 32'd20);
    repeat (6) step();

    // Flush: requester 1's in-flight ops vanish, requester 0 unaffected.
    cnt1 = 0;
    lat0 = 99;
    set_req(1, 32'd11, 32'd11, FUNCT3_MUL, 5'd3);
    req_valid = 2'b10;
    step();
    set_req(1, 32'd12, 32'd12, FUNCT3_MUL, 5'd4);
    step();
    set_req(0, 32'd6, 32'd7, FUNCT3_MUL, 5'd8);
    req_valid = 2'b01;
    step();
    req_valid = '0;
    flush = 2'b10;
    step();
    flush = '0;
    for (int n = 2; n <= 10; n++) begin
      step();
      if (obs_rv[1]) cnt1++;
      if (obs_rv[0] && lat0 == 99) lat0 = n;
    end
    chk("flush_no_rsp1", cnt1, 0);
    chk("flush_req0_latency", lat0, 4);

    // Random traffic against the queue model.
    for (int n = 0; n < 400; n++) begin
      for (int r = 0; r < NREQ; r++) begin
        set_req(r, $urandom, $urandom, 3'($urandom_range(0, 3)), 5'($urandom));
        req_valid[r] = ($urandom_range(0, 9) < 6);
        rsp_ready[r] = ($urandom_range(0, 3) != 0);
        flush[r]     = ($urandom_range(0, 31) == 0);
      end
      step();
    end
    req_valid = '0;
    flush     = '0;
    rsp_ready = '1;
    repeat (10) step();
    chk("perf_issue", perf_issue, PERF ? 64'(m_issue) : 64'd0);
    chk("perf_bp", perf_bp, PERF ? 64'(m_bp) : 64'd0);
    chk("perf_busy", perf_busy, PERF ? 64'(m_busy) : 64'd0);

    // Reset with three ops in flight, then a fresh op at nominal latency.
    set_req(0, 32'd2, 32'd2, FUNCT3_MUL, 5'd1);
    set_req(1, 32'd3, 32'd3, FUNCT3_MUL, 5'd2);
    req_valid = '1;
    repeat (3) step();
    do_reset();
    repeat (3) step();
    single_op(tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
- Shares one pipelined multiplier datapath (MUL/MULH/MULHSU/MULHU, fixed-latency, clock-enable-stalled) between NREQ requesters, e.g. the integer pipeline EX stage and a vector/accelerator port.
- Does round-robin issue, tracks in-flight ops in a shadow pipeline, and routes each result back with its tag to the issuing requester.
- Applies response backpressure by dropping the multiplier clock enable, which freezes the whole datapath.

Parameters:
- NREQ, 2, number of requesters (2..4)
- LATENCY, 4, CE-enabled clock edges from operand capture to valid product at the multiplier output
- TAG_W, 5, requester tag width (e.g. rd index)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  request valid, one bit per requester
- req_ready  out  NREQ  request accepted this cycle
- req_a, req_b  in  NREQ*32  operands, packed with requester i at [32*i +: 32]
- req_funct3  in  NREQ*3  op select (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU)
- req_tag  in  NREQ*TAG_W  opaque tag, returned with the result
- flush  in  NREQ  kill all in-flight and offered ops of requester i
- rsp_valid  out  NREQ  result valid for requester i
- rsp_ready  in  NREQ  requester i accepts the result
- rsp_result  out  32  shared result bus, qualified by rsp_valid
- rsp_tag  out  TAG_W  tag of the presented result
- mul_ce  out  1  multiplier clock enable
- mul_a, mul_b  out  32  multiplier operands
- mul_funct3  out  3  funct3 of the op in the output slot; drives the result mux
- mul_result  in  32  multiplier output, valid LATENCY CE-edges after issue

Behaviour:
- Reset: all shadow slots invalid; rr pointer = 0 (requester 0 highest priority); req_ready = 0, rsp_valid = 0, mul_ce = 0.
- Shadow pipeline: LATENCY slots, each holding {valid, id, tag, funct3}.
  - Slots shift only on edges where mul_ce = 1.
  - Slot 0 loads the granted request, or a bubble if no grant.
  - The output slot is slot LATENCY-1.
- out_blk = out.valid && !rsp_ready[out.id] && !flush[out.id].
- mul_ce = !out_blk && (any slot valid || any grant). A fully idle unit holds CE low.
- Arbitration:
  - Combinational round-robin over req_valid & ~flush, starting at rr pointer.
  - grant one-hot; req_ready[i] = grant[i] && !out_blk.
  - The handshake (req_valid && req_ready) loads slot 0 and drives mul_a/mul_b from that requester.
  - rr pointer becomes (granted id + 1) mod NREQ, only on a completed handshake.
- Back-to-back: one issue per cycle; throughput 1 op/cycle with no backpressure.
- Latency: issue at edge t, rsp_valid high in the cycle after edge t+LATENCY-1. Equivalently, LATENCY cycles after the req_ready cycle, with no stalls.
- Response:
  - rsp_valid[i] = out.valid && out.id == i && !flush[i].
  - rsp_result = mul_result; rsp_tag = out.tag; mul_funct3 = out.funct3.
  - With mul_ce = 0, values hold stable until accepted.
- Backpressure: while out_blk, every slot and the multiplier freeze; no new grant.
- Flush[i]: at the next edge, clears valid on every slot with id == i, regardless of mul_ce. That cycle: no grant to i, rsp_valid[i] = 0, and i does not block CE. Other requesters' slots are unaffected.
- Simultaneous handshake and output accept: both happen in the same edge.
- Reset mid-operation drops all in-flight ops. The multiplier's internal contents are don't-care because the shadow valids gate them.
- mul_a/mul_b/mul_funct3 when idle: all zero.

Optional Feature:
- MUL_ARBITER_PERF_EN defined:
  - Adds 32-bit counters perf_issue (handshakes), perf_bp (cycles with out_blk) and perf_busy (cycles any slot valid).
  - Output ports of the same names; counters wrap at 2^32 and reset to 0.
- Undefined: ports still present, tied to 0, no counter flops.

Decomposition:
- mul_arb_pkg: funct3 constants (FUNCT3_MUL, FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU) and the shadow slot struct typedef.
- Sub-module rr_arbiter (NREQ-wide, pointer in, one-hot grant out, combinational) instantiated once.

Test Plan:
- Single op: req 0 issues a=7, b=-3, funct3=000, tag=5 -> rsp_valid[0] 4 cycles after req_ready, rsp_result=0xFFFFFFEB, rsp_tag=5.
- Contention: both requesters valid for 4 cycles -> grants alternate 0,1,0,1. Results return in the same order with the correct ids; throughput 1/cycle.
- Backpressure: rsp_ready[0]=0 for 3 cycles with result pending -> mul_ce=0, req_ready=0, and rsp_result held for those cycles. Release: accepted, next result follows the next cycle.
- Flush: requester 1 has 2 ops in flight, pulse flush[1] -> no rsp_valid[1] ever. Interleaved requester-0 results arrive with unchanged latency.
- MULH/MULHU: a=0xFFFFFFFF, b=0xFFFFFFFF, funct3=001 -> 0x00000000; funct3=011 -> 0xFFFFFFFE.
- Reset mid-flight: assert reset with 3 ops in flight -> all rsp_valid=0. After release, first new op returns with the nominal latency; PERF counters (if enabled) read 0.
